// File: rtl/wordle_guess_ctrl.sv
// wordle_guess_ctrl
// -----------------------------------------------------------------------------
// Game-sequencing controller between the on-screen keyboard FSM and the board
// display. It collects letters into a guess and handles backspace and enter.
// On enter it scores the guess against the latched answer, one letter per
// cycle. It then either returns to entry, or finishes the game with win/lose.
//
// Ports
//   Clk           system clock, rising edge
//   reset         synchronous active-high reset
//   Start         QI: latch answer, clear game state, begin entry
//   Ack           QDONE: return to QI
//   answer        five 5-bit letter codes, letter 0 in [4:0] (0=A .. 25=Z)
//   key_valid     pulse: key_letter selected
//   key_letter    letter code accompanying key_valid
//   bksp          pulse: delete last letter
//   enter         pulse: submit guess
//   q_I/q_Entry/q_Check/q_Done  one-hot state
//   guess         current guess letters, same packing as answer
//   letter_count  letters entered (0..5)
//   guess_row     completed guesses (0..6)
//   result        2 bits per letter: 00 gray, 01 yellow, 10 green
//   result_valid  one-cycle pulse when result is complete
//   win, lose     game outcome, held until the next Start
//   done          mirrors q_Done for the keyboard FSM
// -----------------------------------------------------------------------------
module wordle_guess_ctrl #(
  parameter int WORD_LEN = 5,
  parameter int MAX_ROWS = 6
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic                    Ack,
  input  logic [5*WORD_LEN-1:0]   answer,
  input  logic                    key_valid,
  input  logic [4:0]              key_letter,
  input  logic                    bksp,
  input  logic                    enter,
  output logic                    q_I,
  output logic                    q_Entry,
  output logic                    q_Check,
  output logic                    q_Done,
  output logic [5*WORD_LEN-1:0]   guess,
  output logic [2:0]              letter_count,
  output logic [2:0]              guess_row,
  output logic [2*WORD_LEN-1:0]   result,
  output logic                    result_valid,
  output logic                    win,
  output logic                    lose,
  output logic                    done
);

  typedef enum logic [3:0] {
    QI     = 4'b0001,
    QENTRY = 4'b0010,
    QCHECK = 4'b0100,
    QDONE  = 4'b1000
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] ans_reg  [WORD_LEN];
  logic [4:0] ans_next [WORD_LEN];
  logic [4:0] slot_reg [WORD_LEN];
  logic [4:0] slot_next[WORD_LEN];
  logic [1:0] res_reg  [WORD_LEN];
  logic [1:0] res_next [WORD_LEN];
  logic [1:0] score    [WORD_LEN];
  logic [2:0] count_reg, count_next;
  logic [2:0] row_reg, row_next;
  logic [2:0] idx_reg, idx_next;
  logic       rv_reg, rv_next;
  logic       win_reg, win_next;
  logic       lose_reg, lose_next;
  logic [1:0] cur_score;
  logic       all_green;

  // Per-letter score for every slot in parallel; the check sequencer just
  // picks the one addressed by the check index. A non-green letter that
  // appears anywhere in the answer is yellow (no duplicate accounting).
  genvar gi, gj;
  generate
    for (gi = 0; gi < WORD_LEN; gi++) begin : g_letter
      logic [WORD_LEN-1:0] hit;
      for (gj = 0; gj < WORD_LEN; gj++) begin : g_hit
        assign hit[gj] = (slot_reg[gi] == ans_reg[gj]);
      end
      assign score[gi] = (slot_reg[gi] == ans_reg[gi]) ? 2'b10 :
                         (|hit)                         ? 2'b01 : 2'b00;
      assign guess[5*gi +: 5]  = slot_reg[gi];
      assign result[2*gi +: 2] = res_reg[gi];
    end
  endgenerate

  assign q_I          = state_reg[0];
  assign q_Entry      = state_reg[1];
  assign q_Check      = state_reg[2];
  assign q_Done       = state_reg[3];
  assign done         = state_reg[3];
  assign letter_count = count_reg;
  assign guess_row    = row_reg;
  assign result_valid = rv_reg;
  assign win          = win_reg;
  assign lose         = lose_reg;

  always_ff @(posedge Clk) begin
    if (reset) state_reg <= QI;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    row_next   = row_reg;
    idx_next   = idx_reg;
    rv_next    = 1'b0;
    win_next   = win_reg;
    lose_next  = lose_reg;
    for (int k = 0; k < WORD_LEN; k++) begin
      ans_next[k]  = ans_reg[k];
      slot_next[k] = slot_reg[k];
      res_next[k]  = res_reg[k];
    end
    cur_score = (idx_reg < 3'(WORD_LEN)) ? score[idx_reg] : 2'b00;
    // Win test on the last letter: earlier letters are already in res_reg.
    all_green = (cur_score == 2'b10);
    for (int k = 0; k < WORD_LEN - 1; k++) begin
      if (res_reg[k] != 2'b10) all_green = 1'b0;
    end

    case (state_reg)
      QI: begin
        if (Start) begin
          for (int k = 0; k < WORD_LEN; k++) begin
            ans_next[k]  = answer[5*k +: 5];
            slot_next[k] = 5'd0;
            res_next[k]  = 2'b00;
          end
          count_next = 3'd0;
          row_next   = 3'd0;
          idx_next   = 3'd0;
          win_next   = 1'b0;
          lose_next  = 1'b0;
          state_next = QENTRY;
        end
      end
      QENTRY: begin
        // Only the highest-priority asserted input acts, even when it is
        // itself ignored.
        if (enter) begin
          if (count_reg == 3'(WORD_LEN)) begin
            idx_next = 3'd0;
            for (int k = 0; k < WORD_LEN; k++) res_next[k] = 2'b00;
            state_next = QCHECK;
          end
        end else if (bksp) begin
          if (count_reg != 3'd0) begin
            for (int k = 0; k < WORD_LEN; k++) begin
              if (3'(k) == count_reg - 3'd1) slot_next[k] = 5'd0;
            end
            count_next = count_reg - 3'd1;
          end
        end else if (key_valid) begin
          if (count_reg < 3'(WORD_LEN) && key_letter <= 5'd25) begin
            for (int k = 0; k < WORD_LEN; k++) begin
              if (3'(k) == count_reg) slot_next[k] = key_letter;
            end
            count_next = count_reg + 3'd1;
          end
        end
      end
      QCHECK: begin
        for (int k = 0; k < WORD_LEN; k++) begin
          if (3'(k) == idx_reg) res_next[k] = cur_score;
        end
        if (idx_reg == 3'(WORD_LEN - 1)) begin
          rv_next  = 1'b1;
          row_next = row_reg + 3'd1;
          if (all_green) begin
            win_next   = 1'b1;
            state_next = QDONE;
          end else if (row_reg + 3'd1 == 3'(MAX_ROWS)) begin
            lose_next  = 1'b1;
            state_next = QDONE;
          end else begin
            for (int k = 0; k < WORD_LEN; k++) slot_next[k] = 5'd0;
            count_next = 3'd0;
            state_next = QENTRY;
          end
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      QDONE: begin
        if (Ack) state_next = QI;
      end
      default: state_next = QI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int k = 0; k < WORD_LEN; k++) begin
        ans_reg[k]  <= 5'd0;
        slot_reg[k] <= 5'd0;
        res_reg[k]  <= 2'b00;
      end
      count_reg <= 3'd0;
      row_reg   <= 3'd0;
      idx_reg   <= 3'd0;
      rv_reg    <= 1'b0;
      win_reg   <= 1'b0;
      lose_reg  <= 1'b0;
    end else begin
      for (int k = 0; k < WORD_LEN; k++) begin
        ans_reg[k]  <= ans_next[k];
        slot_reg[k] <= slot_next[k];
        res_reg[k]  <= res_next[k];
      end
      count_reg <= count_next;
      row_reg   <= row_next;
      idx_reg   <= idx_next;
      rv_reg    <= rv_next;
      win_reg   <= win_next;
      lose_reg  <= lose_next;
    end
  end

endmodule

// File: doc/wordle_guess_ctrl.md
# wordle_guess_ctrl

Game-sequencing controller that sits between the on-screen keyboard FSM and the board display. It collects selected letters into a 5-letter guess and supports backspace and enter. On enter it scores the guess against the answer, one letter per cycle, and tracks the guess row (max 6). It signals win/lose and raises `done` back to the keyboard FSM, which then leaves its run state.

## Interface
- `WORD_LEN`, 5, letters per guess (fixed; checked by bench only at 5)
- `MAX_ROWS`, 6, guesses allowed before loss
- `Clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- `Start`  in  1  in QI: latch `answer`, begin game
- `Ack`  in  1  in QDONE: return to QI
- `answer`  in  25  five 5-bit letter codes, letter 0 in [4:0]; code 0=A … 25=Z
- `key_valid`  in  1  one-cycle pulse: keyboard letter selected
- `key_letter`  in  5  letter code accompanying `key_valid`
- `bksp`  in  1  one-cycle pulse: delete last letter
- `enter`  in  1  one-cycle pulse: submit guess
- `q_I`, `q_Entry`, `q_Check`, `q_Done`  out  1 each  one-hot state
- `guess`  out  25  current guess letters, same packing as `answer`
- `letter_count`  out  3  letters entered, 0..5
- `guess_row`  out  3  completed guesses, 0..6
- `result`  out  10  2 bits per letter, letter i in [2i+1:2i]: 00 gray, 01 yellow, 10 green
- `result_valid`  out  1  one-cycle pulse when `result` complete
- `win`, `lose`  out  1 each  game outcome, held in QDONE
- `done`  out  1  equals `q_Done`; drives keyboard FSM `done`

## Operation
- States: QI, QENTRY, QCHECK, QDONE; one-hot encoded. Any illegal encoding goes to QI on the next clock.
- QI:
  - `Start` latches `answer` into an internal register.
  - Clears `guess`, `letter_count`, `guess_row`, `result`, `win` and `lose`.
  - Goes to QENTRY.
- QENTRY: per-cycle priority is `enter` > `bksp` > `key_valid`; only the highest-priority asserted input acts.
  - `enter` with `letter_count`==5: clear the check index to 0, clear `result`, go to QCHECK. With count<5: ignored.
  - `bksp` with count>0: count−1, vacated letter slot zeroed. With count==0: ignored.
  - `key_valid` with count<5 and `key_letter`≤25: writes slot[count], count+1. With count==5 or code>25: ignored.
- QCHECK: each cycle scores letter index i, for i = 0..4.
  - green if guess[i]==answer[i].
  - else yellow if guess[i] equals any answer[j].
  - else gray.
  - Duplicate-letter counting is not modelled: every non-green match anywhere in the answer is yellow.
  - All letter inputs are ignored while in QCHECK.
- After scoring i=4:
  - Pulse `result_valid` and increment `guess_row`.
  - All five green: set `win`, go to QDONE.
  - Else if the new `guess_row`==6: set `lose`, go to QDONE.
  - Else: clear `guess` and `letter_count`, go to QENTRY.
- QDONE: `result`, `guess`, `win`, `lose` and `guess_row` hold. `Ack` goes to QI. `Start` is ignored in QDONE.
- `reset` applies at any time, including mid-check; it overrides every other input.

## Timing
- Reset values: state QI (`q_I`=1, others 0). `guess`=0, `letter_count`=0, `guess_row`=0, `result`=0, `result_valid`=0, `win`=0, `lose`=0, `done`=0.
- Inputs are sampled at the rising edge; all outputs are registered.
- Key entry: `key_valid` at edge N makes `guess` and `letter_count` update at N+1.
- Check latency: `enter` accepted at edge N gives QCHECK from N+1.
  - Letters 0..4 are scored at edges N+1..N+5.
  - `result_valid`=1, and the state move to QENTRY or QDONE, are visible after edge N+5.
  - `result_valid` is high for exactly one cycle.
- `result` bits for letter i are written on the edge that scores letter i, so they fill progressively. The whole vector is final when `result_valid` is asserted.
- `done` asserts the same cycle QDONE is entered and drops the cycle after `Ack` is sampled.

## Test plan
- Reset then Start with `answer`=CRANE. Keys C,R,A,N,E then `enter` → `result`=10_10_10_10_10 on `result_valid` 6 cycles after `enter`; `win`=1, `q_Done`=1, `guess_row`=1.
- Answer CRANE, guess NACRE → `result`: N=01, A=01, C=01, R=01, E=10; `guess_row`=1; back in QENTRY with `letter_count`=0.
- Entry boundaries:
  - Six `key_valid` pulses → count stays 5 and the sixth letter is dropped.
  - `enter` at count 4 → no state change.
  - `bksp` ×6 from 5 → count 0 and `guess`=0.
  - `enter`+`bksp`+`key_valid` asserted in the same cycle at count 5 → check starts and `guess` is unchanged.
- Six wrong guesses (ZZZZZ vs CRANE) → each gives `result`=0; after the sixth, `lose`=1, `guess_row`=6, QDONE. `Ack` → QI with all outputs still held until the next Start.
- `reset` asserted at the third QCHECK cycle → next cycle is QI with every output at its reset value. `key_valid` pulses during QCHECK leave `guess` unchanged.
- `key_letter`=26 with `key_valid` → ignored. `Start` pulsed in QDONE → ignored.
